// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module  : mem_access_unit_pkg
// Brief   : Shared memory map, FSM state encoding and address decode helper.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

    localparam logic [31:0] c_ram_base      = 32'h1001_0000;
    localparam logic [31:0] c_gpio_out_addr = 32'hFFFF_0000;
    localparam logic [31:0] c_gpio_in_addr  = 32'hFFFF_0004;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RGN_RAM      = 2'd0,
        RGN_GPIO_OUT = 2'd1,
        RGN_GPIO_IN  = 2'd2,
        RGN_ERR      = 2'd3
    } region_e;

    // The RAM window holds 2**ram_aw words, i.e. 2**(ram_aw+2) bytes above ram_base.
    function automatic region_e decode_addr(
        input logic [31:0] addr,
        input logic [31:0] ram_base,
        input int unsigned ram_aw,
        input logic [31:0] gpio_out_addr,
        input logic [31:0] gpio_in_addr
    );
        logic [31:0] off;
        off = addr - ram_base;
        if (addr[1:0] != 2'b00) begin
            return RGN_ERR;
        end
        if ((addr >= ram_base) && ((off >> (ram_aw + 2)) == 32'd0)) begin
            return RGN_RAM;
        end
        if (addr == gpio_out_addr) begin
            return RGN_GPIO_OUT;
        end
        if (addr == gpio_in_addr) begin
            return RGN_GPIO_IN;
        end
        return RGN_ERR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchronizer for asynchronous input pins.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : Data-side access stage: decodes a word request to RAM/GPIO/error,
//           sequences sync-RAM timing and returns MDR with a response pulse.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W        = 8,
    parameter logic [31:0] RAM_BASE      = c_ram_base,
    parameter logic [31:0] GPIO_OUT_ADDR = c_gpio_out_addr,
    parameter logic [31:0] GPIO_IN_ADDR  = c_gpio_in_addr,
    parameter int unsigned GPIO_W        = 8,
    parameter int unsigned WAIT_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out
);

    localparam logic [3:0] c_wait_last = 4'(WAIT_CYCLES - 1);

    state_e            state_q,    state_d;
    region_e           region_q,   region_d;
    logic              we_q,       we_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       mdr_q,      mdr_d;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;

    logic [GPIO_W-1:0] w_gpio_in_sync;
    region_e           w_region;
    logic [31:0]       w_offset;
    logic [ADDR_W-1:0] w_ram_word;

    sync_2ff #(
        .WIDTH (GPIO_W)
    ) u_gpio_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_in),
        .q   (w_gpio_in_sync)
    );

    assign w_region   = decode_addr(req_addr, RAM_BASE, ADDR_W, GPIO_OUT_ADDR, GPIO_IN_ADDR);
    assign w_offset   = req_addr - RAM_BASE;
    assign w_ram_word = ADDR_W'(w_offset >> 2);

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ram_addr_d = ram_addr_q;
        mdr_d      = mdr_q;
        gpio_out_d = gpio_out_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    region_d = w_region;
                    if (w_region == RGN_RAM) begin
                        ram_addr_d = w_ram_word;
                    end
                    if (w_region == RGN_ERR) begin
                        // An erroring read still counts as a read: MDR shows zero.
                        if (!req_we) begin
                            mdr_d = '0;
                        end
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                wait_cnt_d = '0;
                state_d    = ST_RESP;
                case (region_q)
                    RGN_RAM: begin
                        state_d = (WAIT_CYCLES != 0) ? ST_WAIT : ST_CAPTURE;
                    end
                    RGN_GPIO_OUT: begin
                        if (we_q) begin
                            gpio_out_d = wdata_q[GPIO_W-1:0];
                        end else begin
                            mdr_d = 32'(gpio_out_q);
                        end
                    end
                    RGN_GPIO_IN: begin
                        if (!we_q) begin
                            mdr_d = 32'(w_gpio_in_sync);
                        end
                    end
                    default: begin
                        state_d = ST_RESP;
                    end
                endcase
            end
            ST_WAIT: begin
                if (wait_cnt_q == c_wait_last) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                if (!we_q) begin
                    mdr_d = ram_rdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            region_q   <= RGN_ERR;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ram_addr_q <= '0;
            mdr_q      <= '0;
            gpio_out_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ram_addr_q <= ram_addr_d;
            mdr_q      <= mdr_d;
            gpio_out_q <= gpio_out_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Strobes come straight from the state register so reset removes them at once.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = (state_q == ST_RESP) && (region_q == RGN_ERR);
    assign rsp_rdata = mdr_q;
    assign ram_we    = (state_q == ST_ACCESS) && (region_q == RGN_RAM) && we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = wdata_q;
    assign gpio_out  = gpio_out_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Self-checking bench: two units (0 and 1 wait states) against a
//           memory-map reference model, directed plus random requests.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [7:0]  gpio_in;

    logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
    logic [31:0] rsp_rdata0, rsp_rdata1, ram_wdata0, ram_wdata1;
    logic [7:0]  ram_addr0, ram_addr1, gpio_out0, gpio_out1;
    logic        ram_we0, ram_we1;
    logic [31:0] ram_rdata0, ram_rdata1;

    logic [31:0] env_mem0 [256] = '{default: '0};
    logic [31:0] env_mem1 [256] = '{default: '0};

    mem_access_unit #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_we(ram_we0), .ram_rdata(ram_rdata0),
        .gpio_in(gpio_in), .gpio_out(gpio_out0)
    );

    mem_access_unit #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_rdata(ram_rdata1),
        .gpio_in(gpio_in), .gpio_out(gpio_out1)
    );

    // Synchronous RAMs attached to each unit
    always @(posedge clk) begin
        if (ram_we0) env_mem0[ram_addr0] <= ram_wdata0;
        ram_rdata0 <= env_mem0[ram_addr0];
    end
    always @(posedge clk) begin
        if (ram_we1) env_mem1[ram_addr1] <= ram_wdata1;
        ram_rdata1 <= env_mem1[ram_addr1];
    end

    logic        rdy [2], vld [2], err [2], weo [2];
    logic [31:0] rdat [2];
    logic [7:0]  radr [2], gout [2];
    always_comb begin
        rdy[0]  = req_ready0; rdy[1]  = req_ready1;
        vld[0]  = rsp_valid0; vld[1]  = rsp_valid1;
        err[0]  = rsp_err0;   err[1]  = rsp_err1;
        weo[0]  = ram_we0;    weo[1]  = ram_we1;
        rdat[0] = rsp_rdata0; rdat[1] = rsp_rdata1;
        radr[0] = ram_addr0;  radr[1] = ram_addr1;
        gout[0] = gpio_out0;  gout[1] = gpio_out1;
    end

    // Count RAM write-enable cycles per unit
    int          we_cnt [2] = '{0, 0};
    logic [7:0]  last_we_addr [2];
    logic [31:0] last_we_data [2];
    always @(negedge clk) begin
        if (ram_we0) begin we_cnt[0]++; last_we_addr[0] = ram_addr0; last_we_data[0] = ram_wdata0; end
        if (ram_we1) begin we_cnt[1]++; last_we_addr[1] = ram_addr1; last_we_data[1] = ram_wdata1; end
    end

    // Reference model state
    logic [31:0] mdl_mem  [2][256];
    logic [7:0]  mdl_gout [2];
    logic [31:0] mdl_mdr  [2];
    int          wait_of  [2] = '{0, 1};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request to unit d and check its response; entered and left on a negedge.
    task automatic xact(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input bit keep, output int waited);
        int lat, wc0, idx, exp_lat;
        bit is_ram, is_gout, is_gin, exp_err;
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
        waited = 0;
        while (!rdy[d] && waited < 50) begin @(negedge clk); waited++; end
        if (!rdy[d]) begin
            chk("accept_timeout", {31'b0, rdy[d]}, 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        wc0 = we_cnt[d];
        #1;
        if (!keep) req_valid[d] = 1'b0;

        is_ram  = (addr[1:0] == 2'b00) && (addr >= 32'h1001_0000) && (addr < 32'h1001_0400);
        is_gout = (addr == 32'hFFFF_0000);
        is_gin  = (addr == 32'hFFFF_0004);
        exp_err = !(is_ram || is_gout || is_gin);
        idx     = is_ram ? int'((addr - 32'h1001_0000) >> 2) : 0;
        exp_lat = is_ram ? 3 + wait_of[d] : (exp_err ? 1 : 2);
        if (is_ram) begin
            if (we) mdl_mem[d][idx] = wd; else mdl_mdr[d] = mdl_mem[d][idx];
        end else if (is_gout) begin
            if (we) mdl_gout[d] = wd[7:0]; else mdl_mdr[d] = {24'b0, mdl_gout[d]};
        end else if (is_gin) begin
            if (!we) mdl_mdr[d] = {24'b0, gpio_in};
        end else if (!we) begin
            mdl_mdr[d] = 32'd0;
        end

        lat = 0;
        do begin @(negedge clk); lat++; end while (!vld[d] && lat < 50);
        chk("latency",   lat, exp_lat);
        chk("rsp_err",   {31'b0, err[d]}, {31'b0, exp_err});
        chk("rsp_rdata", rdat[d], mdl_mdr[d]);
        chk("ready_low_in_resp", {31'b0, rdy[d]}, 32'd0);
        chk("gpio_out",  {24'b0, gout[d]}, {24'b0, mdl_gout[d]});
        chk("ram_we_cycles", we_cnt[d] - wc0, (is_ram && we) ? 1 : 0);
        if (is_ram) chk("ram_addr", {24'b0, radr[d]}, idx);
        if (is_ram && we) begin
            chk("we_addr", {24'b0, last_we_addr[d]}, idx);
            chk("we_data", last_we_data[d], wd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, d, k, idx;
        logic [31:0] a, v;

        rst = 1'b1;
        gpio_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
            mdl_gout[i] = 8'h00; mdl_mdr[i] = 32'd0;
            for (int j = 0; j < 256; j++) mdl_mem[i][j] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready",     {31'b0, rdy[i]}, 32'd1);
            chk("reset_rsp_valid", {31'b0, vld[i]}, 32'd0);
            chk("reset_rsp_err",   {31'b0, err[i]}, 32'd0);
            chk("reset_rdata",     rdat[i], 32'd0);
            chk("reset_ram_we",    {31'b0, weo[i]}, 32'd0);
            chk("reset_ram_addr",  {24'b0, radr[i]}, 32'd0);
            chk("reset_ram_wdata", (i == 0) ? ram_wdata0 : ram_wdata1, 32'd0);
            chk("reset_gpio_out",  {24'b0, gout[i]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed: RAM write/read on both wait settings, GPIO, errors, last word
        for (int i = 0; i < 2; i++) begin
            xact(i, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, w);
            xact(i, 1'b0, 32'h1001_0004, 32'h0, 1'b0, w);
            xact(i, 1'b1, 32'hFFFF_0000, 32'h0000_00A5, 1'b0, w);
            xact(i, 1'b0, 32'h1001_0002, 32'h0, 1'b0, w);
            xact(i, 1'b1, 32'h1001_0400, 32'h1111_2222, 1'b0, w);
            xact(i, 1'b1, 32'h1001_03FC, 32'hCAFE_F00D, 1'b0, w);
            xact(i, 1'b0, 32'h1001_03FC, 32'h0, 1'b0, w);
            xact(i, 1'b0, 32'hFFFF_0000, 32'h0, 1'b0, w);
        end
        gpio_in = 8'h3C;
        repeat (3) @(negedge clk);
        xact(1, 1'b0, 32'hFFFF_0004, 32'h0, 1'b0, w);
        xact(0, 1'b0, 32'hFFFF_0004, 32'h0, 1'b0, w);
        xact(0, 1'b1, 32'hFFFF_0004, 32'h0000_0077, 1'b0, w);

        // Back-to-back: held request accepted in the IDLE cycle after RESP
        xact(0, 1'b1, 32'hFFFF_0000, 32'h0000_005A, 1'b1, w);
        xact(0, 1'b1, 32'hFFFF_0000, 32'h0000_005A, 1'b0, w2);
        chk("b2b_idle_gap", w2, 1);

        // Asynchronous reset during the WAIT state of a RAM write
        req_we[1] = 1'b1; req_addr[1] = 32'h1001_0010; req_wdata[1] = 32'h1234_5678; req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("rst_test_we_access", {31'b0, weo[1]}, 32'd1);
        @(negedge clk);
        chk("rst_test_we_wait", {31'b0, weo[1]}, 32'd0);
        req_we[1] = 1'b0; req_valid[1] = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ram_we",   {31'b0, weo[1]}, 32'd0);
        chk("async_rst_ready",    {31'b0, rdy[1]}, 32'd1);
        chk("async_rst_gpio_out", {24'b0, gout[1]}, 32'd0);
        chk("async_rst_gpio_out0", {24'b0, gout[0]}, 32'd0);
        mdl_mem[1][4] = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin mdl_gout[i] = 8'h00; mdl_mdr[i] = 32'd0; end
        @(negedge clk);
        rst = 1'b0;
        xact(1, 1'b0, 32'h1001_0010, 32'h0, 1'b0, w);
        chk("first_edge_accept", w, 0);

        // Random requests against the reference model
        for (int n = 0; n < 120; n++) begin
            d   = int'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 9));
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            a   = 32'h1001_0000 + 32'(idx * 4);
            v   = $urandom;
            case (k)
                0, 1, 2: xact(d, 1'b1, a, v, 1'b0, w);
                3, 4, 5: xact(d, 1'b0, a, v, 1'b0, w);
                6:       xact(d, 1'b1, 32'hFFFF_0000, v, 1'b0, w);
                7: begin
                    gpio_in = 8'($urandom);
                    repeat (3) @(negedge clk);
                    xact(d, 1'b0, 32'hFFFF_0004, v, 1'b0, w);
                end
                8:       xact(d, 1'b1, 32'hFFFF_0004, v, 1'b0, w);
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = a | 32'(1 + $urandom_range(0, 2));
                        1:       a = 32'h1001_0400 + 32'(4 * $urandom_range(0, 63));
                        2:       a = 32'h1000_FFFC;
                        default: a = {$urandom} & 32'h0FFF_FFFC;
                    endcase
                    xact(d, $urandom_range(0, 1) == 1, a, v, 1'b0, w);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
